// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: reset PC, instruction size, FSM states
// and the queued {pc, instr} entry.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
  localparam int INST_BYTES = 4;

  typedef enum logic {
    FETCH_RUN,
    FETCH_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO between the ROM port and decode.
// Flush wins over push and pop; full already credits a same-cycle pop.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH)) && !pop;
  assign do_pop  = pop && !flush && !empty;
  assign do_push = push && !flush && !full;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, ROM range check, fault FSM and
// redirect handling in front of the instruction queue.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = XLEN,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = TEXT_BASE_DEFAULT,
  parameter int                    QUEUE_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] Address_o,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  input  logic                  Redirect_valid_i,
  input  logic [DATA_WIDTH-1:0] Redirect_target_i,
  output logic                  Inst_valid_o,
  output logic [DATA_WIDTH-1:0] Inst_o,
  output logic [DATA_WIDTH-1:0] Inst_pc_o,
  input  logic                  Inst_ready_i,
  output logic                  Fault_o,
  output logic [DATA_WIDTH-1:0] Fault_pc_o
);

  // One extra bit so the end bound cannot wrap.
  localparam logic [DATA_WIDTH:0] TEXT_END =
    {1'b0, TEXT_BASE} + (DATA_WIDTH+1)'(INST_BYTES * MEMORY_DEPTH);

  fetch_state_t            state;
  logic [DATA_WIDTH-1:0]   pc;
  logic                    legal;
  logic                    pop;
  logic                    push;
  logic                    fault_now;
  logic                    q_full;
  logic                    q_empty;
  logic [2*DATA_WIDTH-1:0] q_head;

  assign legal = (pc[1:0] == 2'b00)
              && (pc >= TEXT_BASE)
              && ({1'b0, pc} < TEXT_END);

  assign Inst_valid_o = !q_empty;
  assign pop          = Inst_valid_o && Inst_ready_i;
  assign push         = (state == FETCH_RUN) && legal
                     && !q_full && !Redirect_valid_i;
  assign fault_now    = (state == FETCH_RUN) && !legal
                     && !Redirect_valid_i;

  assign Address_o = pc;
  assign Inst_pc_o = q_head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign Inst_o    = q_head[DATA_WIDTH-1:0];

  fetch_queue #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (Redirect_valid_i),
    .din   ({pc, Instruction_i}),
    .full  (q_full),
    .empty (q_empty),
    .head  (q_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FETCH_RUN;
      pc         <= TEXT_BASE;
      Fault_o    <= 1'b0;
      Fault_pc_o <= '0;
    end else begin
      unique case (1'b1)
        Redirect_valid_i: begin
          state      <= FETCH_RUN;
          pc         <= Redirect_target_i;
          Fault_o    <= 1'b0;
          Fault_pc_o <= '0;
        end
        push: begin
          pc <= pc + DATA_WIDTH'(INST_BYTES);
        end
        fault_now: begin
          state      <= FETCH_FAULT;
          Fault_o    <= 1'b1;
          Fault_pc_o <= pc;
        end
        default: begin
          pc <= pc;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Initiator side of the instruction-fetch interface. It owns the program counter, drives the word address into the combinational program ROM, and captures each returned instruction with its PC into a small queue. The queue feeds the decode stage over a valid/ready handshake. It sits between the program ROM and decode, and accepts branch/jump redirects from execute.

## Interface
- DATA_WIDTH, 32, width of address, PC and instruction
- MEMORY_DEPTH, 64, number of instruction words in the ROM
- TEXT_BASE, 32'h0040_0000, byte address of ROM word 0; reset PC
- QUEUE_DEPTH, 2, instruction queue entries (power of two, ≥2)
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- Address_o  output  DATA_WIDTH  byte fetch address to the ROM; equals the current PC
- Instruction_i  input  DATA_WIDTH  ROM read data for Address_o, valid in the same cycle
- Redirect_valid_i  input  1  load a new PC and flush the queue
- Redirect_target_i  input  DATA_WIDTH  new PC (byte address)
- Inst_valid_o  output  1  queue head holds an instruction
- Inst_o  output  DATA_WIDTH  instruction at the queue head
- Inst_pc_o  output  DATA_WIDTH  PC of Inst_o
- Inst_ready_i  input  1  decode accepts the head this cycle
- Fault_o  output  1  fetch halted on an illegal PC (sticky)
- Fault_pc_o  output  DATA_WIDTH  offending PC, held while Fault_o=1

## Operation
- States are FETCH_RUN and FETCH_FAULT. Reset enters FETCH_RUN with PC=TEXT_BASE.
- PC is legal when PC[1:0]==0 and TEXT_BASE ≤ PC < TEXT_BASE+4·MEMORY_DEPTH. The comparison is unsigned.
- Pop: a pop occurs when Inst_valid_o && Inst_ready_i. The head is removed at the edge.
- Push: a push occurs in FETCH_RUN with a legal PC, when the queue is not full or a pop occurs this cycle, and no redirect is present.
  - At the edge, {PC, Instruction_i} is enqueued and PC ← PC+4 (mod 2^32).
- Stall: with the queue full and no pop, PC holds and Address_o is stable.
- Illegal PC in FETCH_RUN with no redirect: nothing is enqueued.
  - At the edge, the state becomes FETCH_FAULT, Fault_o←1 and Fault_pc_o←PC.
  - Queued entries keep draining normally.
- FETCH_FAULT: no pushes and PC holds. The only exits are redirect and reset.
- Redirect has the highest priority over push, pop and fault.
  - At the edge: queue count←0, PC←Redirect_target_i, state←FETCH_RUN, Fault_o←0, Fault_pc_o←0.
  - The target is range-checked in the following cycle, when it becomes PC.
  - A head accepted during the redirect cycle is considered consumed; ignoring it is decode's responsibility.
- Inst_valid_o = (count≠0). Inst_o and Inst_pc_o come from registered queue storage, with no combinational path from Instruction_i.
- When Inst_valid_o=0, Inst_o and Inst_pc_o are 0.

## Timing
- Reset values:
  - Address_o = TEXT_BASE
  - Inst_valid_o = 0, Inst_o = 0, Inst_pc_o = 0
  - Fault_o = 0, Fault_pc_o = 0
  - Queue count = 0
- Reset assertion takes effect immediately (asynchronous), including mid-stream. Operation resumes at the first edge after release.
- Fetch-to-decode latency is one cycle. An instruction fetched in cycle n is presented with Inst_valid_o=1 in cycle n+1.
- Throughput is one instruction per cycle while Inst_ready_i=1. A simultaneous push and pop on a full queue is allowed and loses no cycle.
- Redirect bubble: Inst_valid_o=0 in the cycle after the redirect. The target instruction is presented in the cycle after that.
- Fault: Fault_o rises one cycle after Address_o first shows the illegal PC.
- Wrap: PC+4 overflowing 2^32 wraps to 0. That value is illegal and faults.

## Structure
- Package fetch_pkg holds:
  - the TEXT_BASE default
  - INST_BYTES=4
  - the fetch_state_t enum {FETCH_RUN, FETCH_FAULT}
  - the queue entry typedef {pc, instr}
- Sub-module fetch_queue: a synchronous FIFO of width 2·DATA_WIDTH and depth QUEUE_DEPTH.
  - Ports: push, pop, flush, full, empty, head data.
  - Flush has priority over push and pop.
  - Full status accounts for a same-cycle pop when the top level decides to push.
- The top level holds the PC register, the range check, the state register and redirect priority.

## Test plan
- Release reset with Inst_ready_i=1: Address_o steps 0x400000, 0x400004, …. Inst_valid_o rises one cycle after release, with Inst_pc_o=0x400000 and Inst_o=rom[0], then one instruction per cycle.
- Hold Inst_ready_i=0 for 5 cycles after reset: the queue holds 2 entries and Address_o stays at 0x400008. Raising ready delivers PCs 0x400000, 0x400004, 0x400008 back-to-back with no loss or duplication.
- Assert a redirect to 0x400020 while the queue is full and ready=1:
  - next cycle, Inst_valid_o=0 and Address_o=0x400020
  - the cycle after, Inst_pc_o=0x400020 with rom[8]
- Run sequentially from reset with ready=1: the last delivered PC is 0x4000FC. Then Fault_o=1 and Fault_pc_o=0x400100, Address_o holds 0x400100, and no further valid.
- Redirect to 0x400002: fault with Fault_pc_o=0x400002. A later redirect to 0x400000 clears Fault_o and fetch resumes at rom[0].
- Assert reset between edges with the queue non-empty and Fault_o=1: all outputs take their reset values immediately, and fetch restarts at 0x400000 after release.
